// File: rtl/ppu_mem_arbiter_if.sv
// Bundle of PPU memory arbiter signals: renderer fetch, CPU PPUDATA access
// and the single-port memory wrapper side.
interface ppu_mem_arbiter_if;
    logic [1:0]  mirror;
    logic        rnd_req;
    logic [13:0] rnd_addr;
    logic        rnd_valid;
    logic [7:0]  rnd_q;
    logic        rnd_miss;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_drop;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_rw;
    logic [7:0]  mem_q;

    modport slave (
        input  mirror, rnd_req, rnd_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
        output rnd_valid, rnd_q, rnd_miss, cpu_busy, cpu_ack, cpu_rdata, cpu_drop,
        output mem_addr, mem_data, mem_rw
    );

    modport master (
        output mirror, rnd_req, rnd_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
        input  rnd_valid, rnd_q, rnd_miss, cpu_busy, cpu_ack, cpu_rdata, cpu_drop,
        input  mem_addr, mem_data, mem_rw
    );
endinterface

// File: rtl/ppu_mem_arbiter.sv
// Shares the single-port PPU memory between renderer fetches (priority) and
// buffered CPU PPUDATA accesses, with a starvation bound and nametable mirroring.
module ppu_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic              clk,
    input logic              rst,
    ppu_mem_arbiter_if.slave bus
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {G_NONE, G_RND, G_CPU} grantT;

    grantT       r_gnt;
    grantT       w_gntNext;
    logic        r_pend;
    logic        r_we;
    logic [13:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_starveCnt;
    logic        r_gntRead;
    logic        r_miss;
    logic        r_ack;
    logic [7:0]  r_rdata;
    logic        r_drop;

    logic        w_busy;
    logic        w_accept;
    logic        w_forced;
    logic [13:0] w_memAddr;
    logic [7:0]  w_memData;
    logic        w_memRw;

    // Nametable addresses fold onto the 2 KiB VRAM; CHR space passes untouched.
    function automatic logic [13:0] mirrorAddr(input logic [13:0] a, input logic [1:0] m);
        logic [10:0] idx;
        case (m)
            2'd0:    idx = a[10:0];
            2'd1:    idx = {a[11], a[9:0]};
            2'd2:    idx = {1'b0, a[9:0]};
            default: idx = {1'b1, a[9:0]};
        endcase
        return a[13] ? {a[13:11], idx} : a;
    endfunction

    assign w_busy   = r_pend | (r_gnt == G_CPU);
    assign w_accept = bus.cpu_req & ~w_busy;
    assign w_forced = r_pend & (r_starveCnt == LIMIT);

    always_comb begin
        w_gntNext = G_NONE;
        if (w_forced)
            w_gntNext = G_CPU;
        else if (bus.rnd_req)
            w_gntNext = G_RND;
        else if (r_pend)
            w_gntNext = G_CPU;
    end

    // CHR space is read-only to the CPU: the slot is spent as a harmless read.
    always_comb begin
        w_memAddr = 14'd0;
        w_memData = 8'd0;
        w_memRw   = 1'b0;
        case (w_gntNext)
            G_RND: w_memAddr = mirrorAddr(bus.rnd_addr, bus.mirror);
            G_CPU: begin
                w_memAddr = mirrorAddr(r_addr, bus.mirror);
                w_memData = r_wdata;
                w_memRw   = r_we & r_addr[13];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= G_NONE;
            r_gntRead <= 1'b0;
            r_miss    <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= 8'd0;
        end else begin
            r_gnt     <= w_gntNext;
            r_gntRead <= (w_gntNext == G_CPU) & ~r_we;
            r_miss    <= w_forced & bus.rnd_req;
            r_ack     <= (r_gnt == G_CPU);
            if ((r_gnt == G_CPU) && r_gntRead)
                r_rdata <= bus.mem_q;
        end
    end

    // A new request can only be accepted once the previous one has fully
    // left the buffer, so load and grant-clear never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 14'd0;
            r_wdata     <= 8'd0;
            r_starveCnt <= 8'd0;
            r_drop      <= 1'b0;
        end else begin
            if (w_gntNext == G_CPU)
                r_pend <= 1'b0;
            else if (w_accept)
                r_pend <= 1'b1;
            if (w_accept) begin
                r_we    <= bus.cpu_we;
                r_addr  <= bus.cpu_addr;
                r_wdata <= bus.cpu_wdata;
            end
            if (w_gntNext == G_CPU)
                r_starveCnt <= 8'd0;
            else if (r_pend && (r_starveCnt != LIMIT))
                r_starveCnt <= r_starveCnt + 8'd1;
            if (bus.cpu_req && w_busy)
                r_drop <= 1'b1;
        end
    end

    assign bus.mem_addr  = w_memAddr;
    assign bus.mem_data  = w_memData;
    assign bus.mem_rw    = w_memRw;
    assign bus.rnd_valid = (r_gnt == G_RND);
    assign bus.rnd_q     = (r_gnt == G_RND) ? bus.mem_q : 8'd0;
    assign bus.rnd_miss  = r_miss;
    assign bus.cpu_busy  = w_busy;
    assign bus.cpu_ack   = r_ack;
    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_drop  = r_drop;

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Directed bench for ppu_mem_arbiter with a behavioural 1-cycle-latency memory
// whose nametable side is indexed only by the linear 11-bit VRAM index.
module tb_ppu_mem_arbiter;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;

    logic [7:0] memArr [0:16383];

    ppu_mem_arbiter_if bus ();

    ppu_mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] memIndex(input logic [13:0] a);
        return a[13] ? {3'b100, a[10:0]} : a;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rw)
            memArr[memIndex(bus.mem_addr)] <= bus.mem_data;
        bus.mem_q <= memArr[memIndex(bus.mem_addr)];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [13:0] addr,
                                 input logic [7:0] wdata, input logic [1:0] mode);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.mirror    = mode;
    endtask

    // Starts a CPU access in the current cycle (c0) and ends in the ack cycle (c3).
    task automatic cpuAccess(input string tag, input logic we, input logic [13:0] addr,
                             input logic [7:0] wdata, input logic [1:0] mode,
                             input logic [10:0] expIdx, input logic expRw, input logic [7:0] expRd);
        applyStimulus(1'b1, we, addr, wdata, mode);
        @(negedge clk);
        checkOutput({tag, "_busyC0"}, 32'(bus.cpu_busy), 32'd0);
        stepCycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idxC1"}, 32'(bus.mem_addr[10:0]), 32'(expIdx));
        checkOutput({tag, "_rwC1"}, 32'(bus.mem_rw), 32'(expRw));
        if (we)
            checkOutput({tag, "_dataC1"}, 32'(bus.mem_data), 32'(wdata));
        stepCycle();
        bus.mirror = 2'd0;
        @(negedge clk);
        checkOutput({tag, "_busyC2"}, 32'(bus.cpu_busy), 32'd1);
        checkOutput({tag, "_ackC2"}, 32'(bus.cpu_ack), 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput({tag, "_ackC3"}, 32'(bus.cpu_ack), 32'd1);
        checkOutput({tag, "_busyC3"}, 32'(bus.cpu_busy), 32'd0);
        if (!we)
            checkOutput({tag, "_rdataC3"}, 32'(bus.cpu_rdata), 32'(expRd));
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        for (int i = 0; i < 16384; i++)
            memArr[i] = 8'h00;
        memArr[14'h0123] = 8'h5A;
        bus.mem_q    = 8'h00;
        bus.rnd_req  = 1'b0;
        bus.rnd_addr = 14'h0000;
        applyStimulus(1'b0, 1'b0, 14'h0000, 8'h00, 2'd0);
        rst = 1'b1;
        repeat (3) stepCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy", 32'(bus.cpu_busy), 32'd0);
        checkOutput("rstAck", 32'(bus.cpu_ack), 32'd0);
        checkOutput("rstDrop", 32'(bus.cpu_drop), 32'd0);
        checkOutput("rstValid", 32'(bus.rnd_valid), 32'd0);
        checkOutput("rstMemAddr", 32'(bus.mem_addr), 32'd0);

        // Basic write then read-back through nametable space.
        stepCycle();
        cpuAccess("wr2005", 1'b1, 14'h2005, 8'hA5, 2'd0, 11'h005, 1'b1, 8'h00);
        stepCycle();
        cpuAccess("rd2005", 1'b0, 14'h2005, 8'h00, 2'd0, 11'h005, 1'b0, 8'hA5);

        // Render fetch from CHR space.
        stepCycle();
        bus.rnd_req  = 1'b1;
        bus.rnd_addr = 14'h0123;
        @(negedge clk);
        checkOutput("rndAddr", 32'(bus.mem_addr), 32'h0123);
        stepCycle();
        bus.rnd_req = 1'b0;
        @(negedge clk);
        checkOutput("rndValid", 32'(bus.rnd_valid), 32'd1);
        checkOutput("rndQ", 32'(bus.rnd_q), 32'h5A);
        stepCycle();
        @(negedge clk);
        checkOutput("rndValidOff", 32'(bus.rnd_valid), 32'd0);
        checkOutput("rndQOff", 32'(bus.rnd_q), 32'h00);

        // Mirroring modes.
        stepCycle();
        cpuAccess("wrMir1", 1'b1, 14'h2C10, 8'h3C, 2'd1, 11'h410, 1'b1, 8'h00);
        stepCycle();
        cpuAccess("rdMir0", 1'b0, 14'h2410, 8'h00, 2'd0, 11'h410, 1'b0, 8'h3C);
        stepCycle();
        cpuAccess("wrMir2", 1'b1, 14'h2C10, 8'h77, 2'd2, 11'h010, 1'b1, 8'h00);
        stepCycle();
        cpuAccess("rdMir2", 1'b0, 14'h2010, 8'h00, 2'd0, 11'h010, 1'b0, 8'h77);
        stepCycle();
        cpuAccess("wrMir3", 1'b1, 14'h2010, 8'h99, 2'd3, 11'h410, 1'b1, 8'h00);
        stepCycle();
        cpuAccess("rdMir3", 1'b0, 14'h2410, 8'h00, 2'd0, 11'h410, 1'b0, 8'h99);

        // Starvation: renderer hogs the port, CPU forced in on the 9th cycle.
        stepCycle();
        bus.rnd_req  = 1'b1;
        bus.rnd_addr = 14'h0040;
        applyStimulus(1'b1, 1'b0, 14'h2005, 8'h00, 2'd0);
        for (int i = 1; i <= 8; i++) begin
            stepCycle();
            bus.cpu_req = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("starveRnd%0d", i), 32'(bus.mem_addr), 32'h0040);
            checkOutput($sformatf("starveValid%0d", i), 32'(bus.rnd_valid), 32'd1);
        end
        stepCycle();
        @(negedge clk);
        checkOutput("forcedAddr", 32'(bus.mem_addr), 32'h2005);
        checkOutput("forcedRw", 32'(bus.mem_rw), 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("missPulse", 32'(bus.rnd_miss), 32'd1);
        checkOutput("missValid", 32'(bus.rnd_valid), 32'd0);
        checkOutput("missAck", 32'(bus.cpu_ack), 32'd0);
        stepCycle();
        bus.rnd_req = 1'b0;
        @(negedge clk);
        checkOutput("starveAck", 32'(bus.cpu_ack), 32'd1);
        checkOutput("starveRdata", 32'(bus.cpu_rdata), 32'hA5);
        checkOutput("missOff", 32'(bus.rnd_miss), 32'd0);

        // CHR write protect plus a dropped second request.
        stepCycle();
        applyStimulus(1'b1, 1'b1, 14'h1000, 8'hEE, 2'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 14'h2005, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("chrAddr", 32'(bus.mem_addr), 32'h1000);
        checkOutput("chrRw", 32'(bus.mem_rw), 32'd0);
        stepCycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("dropSet", 32'(bus.cpu_drop), 32'd1);
        checkOutput("dropNotPending", 32'(bus.mem_addr), 32'h0000);
        stepCycle();
        @(negedge clk);
        checkOutput("chrAck", 32'(bus.cpu_ack), 32'd1);
        stepCycle();
        cpuAccess("rdChr1000", 1'b0, 14'h1000, 8'h00, 2'd0, 11'h000, 1'b0, 8'h00);
        checkOutput("dropSticky", 32'(bus.cpu_drop), 32'd1);

        // Reset landing on the grant cycle of a CPU read.
        stepCycle();
        applyStimulus(1'b1, 1'b0, 14'h2005, 8'h00, 2'd0);
        stepCycle();
        bus.cpu_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstGntAddr", 32'(bus.mem_addr), 32'h2005);
        stepCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstMidAck", 32'(bus.cpu_ack), 32'd0);
        checkOutput("rstMidBusy", 32'(bus.cpu_busy), 32'd0);
        checkOutput("rstMidDrop", 32'(bus.cpu_drop), 32'd0);
        checkOutput("rstMidRdata", 32'(bus.cpu_rdata), 32'd0);
        checkOutput("rstMidMemAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rstMidValid", 32'(bus.rnd_valid), 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("rstLateAck", 32'(bus.cpu_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ppu_mem_arbiter.md
Name: ppu_mem_arbiter

Overview:
- Shares the single-port PPU memory (CHR ROM at $0000-$1FFF, nametable VRAM at $2000-$3FFF, 1-cycle synchronous read latency) between two requesters.
- The renderer's tile/attribute/pattern fetches have fixed priority. CPU PPUDATA ($2007) reads and writes are buffered and slotted into idle cycles, with a starvation bound.
- Also applies nametable mirroring so the memory wrapper always sees a linear 11-bit VRAM index. Sits between the PPU register/render logic and the PPU memory wrapper.

Parameters:
STARVE_LIMIT, 8, consecutive cycles a pending CPU access may lose arbitration before it is forced ahead of the renderer (legal range 1-255).

Ports:
clk  input  1  PPU clock
rst  input  1  synchronous active-high reset
mirror  input  2  0 vertical, 1 horizontal, 2 single-screen A, 3 single-screen B
rnd_req  input  1  render fetch request this cycle (no backpressure)
rnd_addr  input  14  render fetch address
rnd_valid  output  1  render read data valid
rnd_q  output  8  render read data
rnd_miss  output  1  pulse: render fetch was displaced by a forced CPU access
cpu_req  input  1  single-cycle request pulse
cpu_we  input  1  1 write, 0 read (sampled with cpu_req)
cpu_addr  input  14  CPU access address (sampled with cpu_req)
cpu_wdata  input  8  write data (sampled with cpu_req)
cpu_busy  output  1  a CPU access is pending or in flight
cpu_ack  output  1  pulse: CPU access complete
cpu_rdata  output  8  registered CPU read data, held until the next CPU read completes
cpu_drop  output  1  sticky: a cpu_req arrived while busy and was discarded
mem_addr  output  14  memory address
mem_data  output  8  memory write data
mem_rw  output  1  1 = write, 0 = read
mem_q  input  8  memory read data, valid the cycle after the address

Behaviour:
- Reset (synchronous, rst high at posedge):
  - Clears the pending buffer, starve counter, grant register and cpu_drop.
  - Any in-flight access completes silently: no ack, no valid.
  - All outputs are 0 in the cycle after reset.
- CPU capture:
  - cpu_req with cpu_busy low latches {we, addr, wdata} into a one-entry buffer; pending is set from the next cycle.
  - cpu_req with cpu_busy high is ignored and sets cpu_drop (sticky until rst).
- Grant, combinational each cycle, in priority order:
  - CPU wins if pending and starve_cnt == STARVE_LIMIT.
  - Otherwise render wins if rnd_req.
  - Otherwise CPU wins if pending.
  - Otherwise none.
  - Grant state is registered as G_NONE / G_RND / G_CPU to align responses one cycle later.
- Memory drive:
  - mem_addr, mem_data and mem_rw are driven combinationally from the granted requester.
  - G_NONE drives addr 0 and rw 0.
  - mem_data is the CPU wdata, otherwise 0.
- Mirroring, applied only when addr[13] = 1:
  - Bits 13:11 pass through; bits 10:0 are remapped.
  - mode 0: addr[10:0]
  - mode 1: {addr[11], addr[9:0]}
  - mode 2: {0, addr[9:0]}
  - mode 3: {1, addr[9:0]}
  - addr[13] = 0 passes unchanged.
  - mirror is sampled per grant; a change affects the next grant only.
- CHR write protect: a CPU write with addr[13] = 0 drives mem_rw = 0 (read) but completes and acks normally.
- Render response: the cycle after a render grant, rnd_valid = 1 and rnd_q = mem_q (passthrough). Otherwise rnd_valid = 0 and rnd_q = 0.
- Forced CPU grant with rnd_req high: the next cycle pulses rnd_miss and leaves rnd_valid = 0.
- CPU response:
  - Cycle after a CPU grant (N+1): pending is cleared; for a read, cpu_rdata <= mem_q at end of cycle.
  - Cycle N+2: cpu_ack = 1 for one cycle; cpu_busy is low; a new cpu_req is accepted in this cycle.
- Latency: minimum cpu_req to cpu_ack is 3 cycles (pulse at c0, grant c1, capture c2, ack c3).
- cpu_busy is high from the cycle after acceptance through the capture cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each cycle pending is set and not granted.
  - Clears to 0 on CPU grant.
- Simultaneous cpu_req and rnd_req in the same cycle: no conflict. cpu_req only loads the buffer; arbitration starts the following cycle.

Test Plan:
- Idle, then cpu write $2005 = 0xA5; 3 cycles later cpu read $2005 (mirror 0). Expect mem_rw = 1 at addr $2005 in c1, ack at c3; the read returns cpu_rdata = 0xA5 with ack 3 cycles after its pulse.
- Mirror: write 0x3C to $2C10 with mirror = 1, then read $2410 with mirror = 0. Expect mem_addr[10:0] = $410 both times and read data 0x3C. Repeat with mirror = 2 and mirror = 3, expecting mem_addr[10:0] = $010 and $410.
- rnd_req held high continuously with a cpu read pending, STARVE_LIMIT = 8. Expect render wins 8 cycles, CPU is granted on the 9th, rnd_miss pulses the following cycle, and cpu_ack arrives 11 cycles after the pulse.
- Render fetch of CHR $0123 returning 0x5A. Expect rnd_valid = 1 and rnd_q = 0x5A exactly one cycle after rnd_req.
- cpu write to $1000, then a second cpu_req while busy. Expect mem_rw = 0 during the write slot with cpu_ack still pulsing; the second request is dropped and cpu_drop = 1 and stays 1.
- rst asserted in the grant cycle of a cpu read. Expect no cpu_ack, cpu_busy = 0, cpu_drop = 0 and all outputs 0 the following cycle.
